uart_cmd_master: RTL and testbench
==================================

// Module: uart_cmd_master
// PURPOSE
//  Host-side initiator for the housekeeping UART command protocol ("xxm" set address,
//  "xxw" write, "r" read -> one reply byte). Converts parallel register requests into
//  8N1 serial command strings and captures the read reply. Used in board-to-board
//  links and as the self-checking driver in system benches against the housekeeping cpu.
// PARAMETERS
//  BAUD_DIV      27   clk cycles per 16x baud tick (matches the housekeeping baud clock)
//  TIMEOUT_BITS  200  bit periods to wait for a read reply before flagging timeout
// PORTS
//  clk          in   1  clock
//  reset        in   1  reset, synchronous, active-high
//  req_valid    in   1  request present; accepted when req_valid & req_ready
//  req_ready    out  1  block idle, able to accept a request
//  req_write    in   1  1 = write, 0 = read
//  req_addr     in   8  target port id
//  req_wdata    in   8  write data (ignored for reads)
//  rsp_valid    out  1  one-cycle pulse: request finished
//  rsp_data     out  8  read byte (0 for writes and timeouts); held until next rsp_valid
//  rsp_timeout  out  1  qualifies rsp_valid: read reply not received in time
//  uart_tx      out  1  serial out, idle high
//  uart_rx      in   1  serial in, asynchronous
// BEHAVIOUR
//  Reset: uart_tx=1, req_ready=1, rsp_valid=0, rsp_data=0, rsp_timeout=0,
//   address cache invalid, baud divider and all bit counters 0, rx synchroniser = 1.
//  Baud: free-running divider 0..BAUD_DIV-1, tick on terminal count; 1 bit = 16 ticks.
//  Nibble char = 8'h30 | nibble (responder uses only 4 LSBs); high nibble first.
//  Command bytes: 'm'=8'h6D, 'w'=8'h77, 'r'=8'h72.
//  Sequence on accept (req_ready drops the cycle after the handshake):
//   - address hi, lo, 'm' -- skipped if cache valid and req_addr == cached address
//   - write: data hi, lo, 'w'; read: 'r'
//   - cache updated to req_addr when its 'm' byte's stop bit completes
//  Request fields latched at accept; later changes on inputs ignored.
//  TX: 8N1, LSB first; start bit begins on first baud tick after byte is loaded;
//   next byte starts immediately after previous stop bit (no idle gap).
//  FSM: IDLE -> SEND (byte index 0..5) -> [read] WAIT_RX -> DONE -> IDLE.
//   DONE lasts one cycle: rsp_valid=1, req_ready returns to 1 the following cycle.
//   Write: DONE entered at end of 'w' stop bit, rsp_data=0, rsp_timeout=0.
//  RX: uart_rx passes 2-flop synchroniser; receiver enabled only in WAIT_RX.
//   Falling edge -> count 8 ticks, start must still be 0 (else false start, rearm);
//   then sample each bit every 16 ticks; stop sampled at 16 ticks after bit 7.
//   Stop = 1: byte -> rsp_data, DONE, rsp_timeout=0.
//   Stop = 0 (framing error): byte discarded, receiver rearms, timeout keeps running.
//  Timeout: bit-period counter starts at end of 'r' stop bit; at TIMEOUT_BITS without
//   a good byte -> DONE with rsp_timeout=1, rsp_data=0, cache invalidated.
//   Byte in progress at timeout is abandoned.
//  Bytes arriving outside WAIT_RX are ignored.
//  req_valid while busy: not accepted, no effect.
//  Reset mid-operation: all outputs to reset values next cycle (uart_tx high
//   mid-frame), no rsp_valid, cache invalid.
// TESTING
//  1 write addr 0x06 data 0x5A from reset -> tx 30,36,6D,35,3A,77; rsp_valid once,
//    timeout 0; each bit 16*27 clk wide.
//  2 read addr 0x21, bench replies 0xA5 -> tx 32,31,6D,72; rsp_data=A5, timeout 0.
//  3 second read addr 0x21 -> tx only 72; write to 0x22 next -> tx 32,32,6D,..,77.
//  4 read, no reply -> rsp_valid with rsp_timeout=1 exactly 200 bit periods after
//    'r' stop; next request resends address.
//  5 reply with stop=0 then good 0x3C -> first discarded, rsp_data=3C, timeout 0.
//  6 reset during 2nd tx byte -> uart_tx=1 next cycle, req_ready=1, no rsp_valid;
//    next read resends address.

Source files
------------

// File: rtl/uart_cmd_master.sv
// Host-side initiator for the housekeeping UART command protocol: turns register
// requests into "xxm" / "xxw" / "r" 8N1 strings and captures the one-byte read reply.
module uart_cmd_master #(
    parameter int BAUD_DIV     = 27,
    parameter int TIMEOUT_BITS = 200
) (
    input  logic       clk,
    input  logic       reset,
    // Handshake: a request transfers on a clk edge where req_valid & req_ready;
    // rsp_valid is a single-cycle pulse with no back-pressure.
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] WAIT_RX = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_BITS + 1);

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             lat_write;
    logic [7:0]       lat_addr;
    logic [7:0]       lat_wdata;
    logic [2:0]       slot;
    logic [2:0]       last_slot;
    logic [7:0]       cur_byte;
    logic             tx_active;
    logic [3:0]       tx_tick;
    logic [3:0]       tx_bit;
    logic             tx_reg;
    logic             cache_valid;
    logic [7:0]       cache_addr;
    logic             rx_s1, rx_s2, rx_prev;
    logic             rx_fall;
    logic             rx_busy;
    logic [3:0]       rx_tick;
    logic [3:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_good;
    logic [3:0]       to_tick;
    logic [TO_W-1:0]  to_bits;
    logic             to_expire;

    assign tick      = (div_cnt == DIV_W'(BAUD_DIV - 1));
    assign last_slot = lat_write ? 3'd5 : 3'd3;
    assign rx_fall   = rx_prev & ~rx_s2;
    assign rx_good   = (state == WAIT_RX) && rx_busy && tick && (rx_bit == 4'd9)
                       && (rx_tick == 4'd15) && rx_s2;
    assign to_expire = (state == WAIT_RX) && tick && (to_tick == 4'd15)
                       && (to_bits == TO_W'(TIMEOUT_BITS - 1));

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign uart_tx   = tx_reg;
    assign dbg_state = state;

    // Slots 0..2 carry the address string, 3..5 the write string or the lone 'r'.
    always_comb begin
        cur_byte = 8'h00;
        case (slot)
            3'd0:    cur_byte = 8'h30 | {4'h0, lat_addr[7:4]};
            3'd1:    cur_byte = 8'h30 | {4'h0, lat_addr[3:0]};
            3'd2:    cur_byte = 8'h6D;
            3'd3:    cur_byte = lat_write ? (8'h30 | {4'h0, lat_wdata[7:4]}) : 8'h72;
            3'd4:    cur_byte = 8'h30 | {4'h0, lat_wdata[3:0]};
            3'd5:    cur_byte = 8'h77;
            default: cur_byte = 8'h00;
        endcase
    end

    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        if (idx == 4'd0)
            return 1'b0;
        else if (idx <= 4'd8)
            return b[3'(idx - 4'd1)];
        else
            return 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            lat_write   <= 1'b0;
            lat_addr    <= 8'h00;
            lat_wdata   <= 8'h00;
            slot        <= 3'd0;
            tx_active   <= 1'b0;
            tx_tick     <= 4'd0;
            tx_bit      <= 4'd0;
            tx_reg      <= 1'b1;
            cache_valid <= 1'b0;
            cache_addr  <= 8'h00;
            rx_busy     <= 1'b0;
            rx_tick     <= 4'd0;
            rx_bit      <= 4'd0;
            rx_shift    <= 8'h00;
            to_tick     <= 4'd0;
            to_bits     <= '0;
            rsp_data    <= 8'h00;
            rsp_timeout <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            case (state)
                IDLE: if (req_valid) begin
                    lat_write <= req_write;
                    lat_addr  <= req_addr;
                    lat_wdata <= req_wdata;
                    slot      <= (cache_valid && req_addr == cache_addr) ? 3'd3 : 3'd0;
                    tx_active <= 1'b0;
                    state     <= SEND;
                end
                SEND: if (tick) begin
                    if (!tx_active) begin
                        tx_active <= 1'b1;
                        tx_bit    <= 4'd0;
                        tx_tick   <= 4'd0;
                        tx_reg    <= 1'b0;
                    end else if (tx_tick != 4'd15) begin
                        tx_tick <= tx_tick + 4'd1;
                    end else begin
                        tx_tick <= 4'd0;
                        if (tx_bit != 4'd9) begin
                            tx_bit <= tx_bit + 4'd1;
                            tx_reg <= frame_bit(cur_byte, tx_bit + 4'd1);
                        end else begin
                            // End of a stop bit: the next byte's start bit follows with no gap.
                            if (slot == 3'd2) begin
                                cache_valid <= 1'b1;
                                cache_addr  <= lat_addr;
                            end
                            if (slot == last_slot) begin
                                tx_active <= 1'b0;
                                if (lat_write) begin
                                    state       <= DONE;
                                    rsp_data    <= 8'h00;
                                    rsp_timeout <= 1'b0;
                                end else begin
                                    state   <= WAIT_RX;
                                    rx_busy <= 1'b0;
                                    to_tick <= 4'd0;
                                    to_bits <= '0;
                                end
                            end else begin
                                slot   <= slot + 3'd1;
                                tx_bit <= 4'd0;
                                tx_reg <= 1'b0;
                            end
                        end
                    end
                end
                WAIT_RX: begin
                    if (tick) begin
                        if (to_tick == 4'd15) begin
                            to_tick <= 4'd0;
                            to_bits <= to_bits + 1'b1;
                        end else begin
                            to_tick <= to_tick + 4'd1;
                        end
                    end
                    if (rx_good) begin
                        state       <= DONE;
                        rsp_data    <= rx_shift;
                        rsp_timeout <= 1'b0;
                        rx_busy     <= 1'b0;
                    end else if (to_expire) begin
                        state       <= DONE;
                        rsp_data    <= 8'h00;
                        rsp_timeout <= 1'b1;
                        rx_busy     <= 1'b0;
                        cache_valid <= 1'b0;
                    end else if (!rx_busy) begin
                        if (rx_fall) begin
                            rx_busy <= 1'b1;
                            rx_tick <= 4'd0;
                            rx_bit  <= 4'd0;
                        end
                    end else if (tick) begin
                        // Bit 0 is the start bit, checked at mid-bit; 1..8 data; 9 stop.
                        if (rx_bit == 4'd0) begin
                            if (rx_tick == 4'd7) begin
                                rx_tick <= 4'd0;
                                if (rx_s2) rx_busy <= 1'b0;
                                else       rx_bit  <= 4'd1;
                            end else begin
                                rx_tick <= rx_tick + 4'd1;
                            end
                        end else if (rx_tick != 4'd15) begin
                            rx_tick <= rx_tick + 4'd1;
                        end else begin
                            rx_tick <= 4'd0;
                            if (rx_bit == 4'd9) begin
                                rx_busy <= 1'b0;
                            end else begin
                                rx_shift <= {rx_s2, rx_shift[7:1]};
                                rx_bit   <= rx_bit + 4'd1;
                            end
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master: decodes uart_tx frames, drives read replies on
// uart_rx and checks responses, caching, timeout and mid-frame reset behaviour.
module tb_uart_cmd_master;

    localparam int DIV     = 5;
    localparam int TO_BITS = 200;
    localparam int BIT     = 16 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       uart_tx;
    logic       uart_rx = 1'b1;
    logic [1:0] dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rsp_cnt = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         got_t_q[$];

    uart_cmd_master #(.BAUD_DIV(DIV), .TIMEOUT_BITS(TO_BITS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

    // ---------------- uart_tx frame decoder ----------------
    logic       mon_busy = 1'b0;
    logic       mon_prev = 1'b1;
    int         mon_cnt = 0;
    int         mon_start = 0;
    logic [7:0] mon_sh = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            mon_busy = 1'b0;
            mon_prev = 1'b1;
        end else if (!mon_busy) begin
            if (mon_prev === 1'b1 && uart_tx === 1'b0) begin
                mon_busy  = 1'b1;
                mon_cnt   = 0;
                mon_start = cyc;
            end
            mon_prev = uart_tx;
        end else begin
            mon_cnt++;
            if (mon_cnt % BIT == BIT / 2 && mon_cnt / BIT >= 1 && mon_cnt / BIT <= 8)
                mon_sh[mon_cnt / BIT - 1] = uart_tx;
            if (mon_cnt == 9 * BIT + BIT / 2) begin
                got_q.push_back({uart_tx, mon_sh});
                got_t_q.push_back(mon_start);
                mon_busy = 1'b0;
                mon_prev = uart_tx;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back({1'b1, b});
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 400 * BIT) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL issue_wait: req_ready=%b after %0d cycles, expected 1", req_ready, n);
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = ~d;
    endtask

    task automatic wait_rsp(input int limit, output bit seen, output int at);
        int n;
        n = 0;
        seen = 1'b0;
        at = 0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic wait_bytes(input int cnt, input int limit);
        int n;
        n = 0;
        while (got_q.size() < cnt && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (uart_tx !== 1'b1)     begin bad++; $display("FAIL rst_tx: got %b expected 1", uart_tx); end
        total++; if (req_ready !== 1'b1)   begin bad++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
        total++; if (rsp_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid: got %b expected 0", rsp_valid); end
        total++; if (rsp_data !== 8'h00)   begin bad++; $display("FAIL rst_data: got %h expected 00", rsp_data); end
        total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b expected 0", rsp_timeout); end
        total++; if (dbg_state !== 2'd0)   begin bad++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_first;
        bit seen;
        int at, n, w, r0;
        got_q.delete(); got_t_q.delete(); exp_q.delete();
        push_exp(8'h30); push_exp(8'h36); push_exp(8'h6D);
        push_exp(8'h35); push_exp(8'h3A); push_exp(8'h77);
        r0 = rsp_cnt;
        issue(1'b1, 8'h06, 8'h5A);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL w_ready_drop: got %b expected 0", req_ready); end
        n = 0;
        while (uart_tx !== 1'b0 && n < 4 * BIT) begin @(negedge clk); n++; end
        w = 0;
        while (uart_tx === 1'b0 && w < 20 * BIT) begin @(negedge clk); w++; end
        // 0x30 sent LSB first: start bit plus four zero data bits stay low
        total++; if (w != 5 * BIT) begin bad++; $display("FAIL w_bit_width: low run %0d cycles expected %0d", w, 5 * BIT); end
        wait_rsp(70 * BIT, seen, at);
        total++; if (!seen) begin bad++; $display("FAIL w_rsp_seen: got 0 expected 1"); end
        total++; if (rsp_data !== 8'h00)   begin bad++; $display("FAIL w_rsp_data: got %h expected 00", rsp_data); end
        total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL w_rsp_timeout: got %b expected 0", rsp_timeout); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL w_pulse_len: got %b expected 0", rsp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL w_ready_back: got %b expected 1", req_ready); end
        total++; if (rsp_cnt - r0 != 1)  begin bad++; $display("FAIL w_rsp_count: got %0d expected 1", rsp_cnt - r0); end
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL w_nbytes: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL w_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_read_reply;
        bit seen;
        int at, r0;
        got_q.delete(); got_t_q.delete(); exp_q.delete();
        push_exp(8'h32); push_exp(8'h31); push_exp(8'h6D); push_exp(8'h72);
        r0 = rsp_cnt;
        issue(1'b0, 8'h21, 8'hFF);
        wait_bytes(4, 50 * BIT);
        repeat (BIT) @(negedge clk);
        fork
            send_rx(8'hA5, 1'b1);
            wait_rsp(20 * BIT, seen, at);
        join
        total++; if (!seen) begin bad++; $display("FAIL r_rsp_seen: got 0 expected 1"); end
        total++; if (rsp_data !== 8'hA5)   begin bad++; $display("FAIL r_rsp_data: got %h expected a5", rsp_data); end
        total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL r_rsp_timeout: got %b expected 0", rsp_timeout); end
        @(negedge clk);
        total++; if (rsp_cnt - r0 != 1) begin bad++; $display("FAIL r_rsp_count: got %0d expected 1", rsp_cnt - r0); end
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL r_nbytes: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL r_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_cached_read;
        bit seen;
        int at;
        got_q.delete(); got_t_q.delete(); exp_q.delete();
        push_exp(8'h72);
        push_exp(8'h32); push_exp(8'h32); push_exp(8'h6D);
        push_exp(8'h38); push_exp(8'h31); push_exp(8'h77);
        issue(1'b0, 8'h21, 8'h00);
        wait_bytes(1, 20 * BIT);
        repeat (BIT) @(negedge clk);
        fork
            send_rx(8'h17, 1'b1);
            wait_rsp(20 * BIT, seen, at);
        join
        total++; if (!seen || rsp_data !== 8'h17) begin bad++; $display("FAIL c_rsp_data: got %h seen %0d expected 17", rsp_data, seen); end
        @(negedge clk);
        issue(1'b1, 8'h22, 8'h81);
        wait_rsp(70 * BIT, seen, at);
        total++; if (!seen || rsp_data !== 8'h00) begin bad++; $display("FAIL c_wr_rsp: got %h seen %0d expected 00", rsp_data, seen); end
        @(negedge clk);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL c_nbytes: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL c_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_framing;
        bit seen;
        int at, r0;
        got_q.delete(); got_t_q.delete(); exp_q.delete();
        push_exp(8'h72);
        r0 = rsp_cnt;
        issue(1'b0, 8'h22, 8'h00);
        wait_bytes(1, 20 * BIT);
        repeat (BIT) @(negedge clk);
        send_rx(8'h55, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        total++; if (rsp_cnt != r0) begin bad++; $display("FAIL f_bad_stop: %0d responses expected 0", rsp_cnt - r0); end
        fork
            send_rx(8'h3C, 1'b1);
            wait_rsp(20 * BIT, seen, at);
        join
        total++; if (!seen) begin bad++; $display("FAIL f_rsp_seen: got 0 expected 1"); end
        total++; if (rsp_data !== 8'h3C)   begin bad++; $display("FAIL f_rsp_data: got %h expected 3c", rsp_data); end
        total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL f_rsp_timeout: got %b expected 0", rsp_timeout); end
        @(negedge clk);
        total++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin bad++; $display("FAIL f_bytes: got %0d bytes first %h expected 1 byte 172", got_q.size(), got_q.size() ? got_q[0] : 9'h0); end
    endtask

    task automatic test_timeout;
        bit seen;
        int at, r0, delta;
        got_q.delete(); got_t_q.delete(); exp_q.delete();
        push_exp(8'h72);
        push_exp(8'h32); push_exp(8'h32); push_exp(8'h6D);
        push_exp(8'h30); push_exp(8'h3F); push_exp(8'h77);
        r0 = rsp_cnt;
        issue(1'b0, 8'h22, 8'h00);
        // a competing request held while busy must not be taken
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h55; req_wdata = 8'hAA;
        wait_rsp(230 * BIT, seen, at);
        req_valid = 1'b0;
        delta = (got_t_q.size() > 0) ? at - got_t_q[0] : -1;
        total++; if (!seen) begin bad++; $display("FAIL t_rsp_seen: got 0 expected 1"); end
        total++; if (rsp_timeout !== 1'b1) begin bad++; $display("FAIL t_flag: got %b expected 1", rsp_timeout); end
        total++; if (rsp_data !== 8'h00)   begin bad++; $display("FAIL t_data: got %h expected 00", rsp_data); end
        total++; if (delta != (10 + TO_BITS) * BIT) begin bad++; $display("FAIL t_latency: got %0d cycles expected %0d", delta, (10 + TO_BITS) * BIT); end
        @(negedge clk);
        issue(1'b1, 8'h22, 8'h0F);
        wait_rsp(70 * BIT, seen, at);
        total++; if (!seen || rsp_timeout !== 1'b0) begin bad++; $display("FAIL t_next_rsp: seen %0d timeout %b expected 1/0", seen, rsp_timeout); end
        @(negedge clk);
        total++; if (rsp_cnt - r0 != 2) begin bad++; $display("FAIL t_rsp_count: got %0d expected 2", rsp_cnt - r0); end
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL t_nbytes: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL t_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        int at, r0;
        got_q.delete(); got_t_q.delete(); exp_q.delete();
        r0 = rsp_cnt;
        issue(1'b1, 8'h22, 8'h00);
        wait_bytes(1, 20 * BIT);
        repeat (3 * BIT) @(negedge clk);
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL m_mid_frame: got %b expected 0", uart_tx); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (uart_tx !== 1'b1)     begin bad++; $display("FAIL m_tx: got %b expected 1", uart_tx); end
        total++; if (req_ready !== 1'b1)   begin bad++; $display("FAIL m_ready: got %b expected 1", req_ready); end
        total++; if (rsp_valid !== 1'b0)   begin bad++; $display("FAIL m_valid: got %b expected 0", rsp_valid); end
        total++; if (rsp_data !== 8'h00)   begin bad++; $display("FAIL m_data: got %h expected 00", rsp_data); end
        total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL m_timeout: got %b expected 0", rsp_timeout); end
        repeat (12 * BIT) @(negedge clk);
        total++; if (rsp_cnt != r0 || got_q.size() != 1) begin bad++; $display("FAIL m_quiet: %0d responses %0d bytes expected 0 and 1", rsp_cnt - r0, got_q.size()); end
        got_q.delete(); got_t_q.delete();
        push_exp(8'h32); push_exp(8'h32); push_exp(8'h6D); push_exp(8'h72);
        issue(1'b0, 8'h22, 8'h00);
        wait_bytes(4, 50 * BIT);
        repeat (BIT) @(negedge clk);
        fork
            send_rx(8'h66, 1'b1);
            wait_rsp(20 * BIT, seen, at);
        join
        total++; if (!seen || rsp_data !== 8'h66) begin bad++; $display("FAIL m_read_data: got %h seen %0d expected 66", rsp_data, seen); end
        @(negedge clk);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL m_nbytes: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL m_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_first();
        test_read_reply();
        test_cached_read();
        test_framing();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
